// File: rtl/bitxor_arb.sv
// rtl/bitxor_arb.sv - two-requester round-robin sequencer for the 1-bit xor register bank
// Optional macro BITXOR_ARB_STATS_EN enables the 16-bit grant counter on stat_count.
module bitxor_arb #(
   parameter int RESULT_LAT = 1,
   parameter int IDX_W      = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [1:0]       a_op,
   input  logic [IDX_W-1:0] a_idx,
   input  logic             a_val,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [1:0]       b_op,
   input  logic [IDX_W-1:0] b_idx,
   input  logic             b_val,
   output logic [1:0]       reg_inst,
   output logic [IDX_W-1:0] reg_idx,
   output logic             reg_in0,
   input  logic             reg_out0,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic             rsp_data,
   output logic             rsp_err,
   output logic [15:0]      stat_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state, state_nxt;
   logic             pref_b;
   logic             lat_query;
   logic [2:0]       wait_cnt;
   logic             wait_done;
   logic             grant_a, grant_b, grant;
   logic [1:0]       win_op;
   logic [IDX_W-1:0] win_idx;
   logic             win_val;
   logic             win_illegal;

   // Grant only from IDLE and never in a reset cycle, so nothing is accepted that reset would drop.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == IDLE && !reset) begin
         if (a_valid && b_valid) begin
            grant_a = !pref_b;
            grant_b = pref_b;
         end else begin
            grant_a = a_valid;
            grant_b = b_valid;
         end
      end
   end

   assign a_ready     = grant_a;
   assign b_ready     = grant_b;
   assign grant       = grant_a | grant_b;
   assign win_op      = grant_b ? b_op  : a_op;
   assign win_idx     = grant_b ? b_idx : a_idx;
   assign win_val     = grant_b ? b_val : a_val;
   assign win_illegal = win_op[0];
   assign wait_done   = (wait_cnt == 3'(RESULT_LAT));
   assign rsp_valid   = (state == RESP);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = win_illegal ? RESP : ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (wait_done) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pref_b    <= 1'b0;
         reg_inst  <= 2'b11;
         reg_idx   <= '0;
         reg_in0   <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= 1'b0;
         rsp_err   <= 1'b0;
         lat_query <= 1'b0;
         wait_cnt  <= 3'd0;
      end else begin
         reg_inst <= 2'b11;
         if (grant) begin
            pref_b    <= !grant_b;
            rsp_id    <= grant_b;
            rsp_data  <= 1'b0;
            rsp_err   <= win_illegal;
            lat_query <= win_op[1];
            // Bank outputs are loaded at the grant edge so they are live during ISSUE only.
            if (!win_illegal) begin
               reg_inst <= win_op;
               reg_idx  <= win_idx;
               reg_in0  <= win_op[1] ? 1'b0 : win_val;
            end
         end
         if (state == ISSUE)
            wait_cnt <= 3'd1;
         else if (state == WAIT && !wait_done)
            wait_cnt <= wait_cnt + 3'd1;
         if (state == WAIT && wait_done)
            rsp_data <= lat_query & reg_out0;
      end
   end

`ifdef BITXOR_ARB_STATS_EN
   logic [15:0] stat_q;
   always_ff @(posedge clk) begin
      if (reset)      stat_q <= 16'd0;
      else if (grant) stat_q <= stat_q + 16'd1;
   end
   assign stat_count = stat_q;
`else
   assign stat_count = 16'd0;
`endif

endmodule

// File: tb/tb_bitxor_arb.sv
// tb/tb_bitxor_arb.sv - self-checking bench for bitxor_arb with a reference arbiter/bank model
// Honours BITXOR_ARB_STATS_EN for the expected stat_count.
module tb_bitxor_arb;
   localparam int LAT = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_valid, a_val, b_valid, b_val;
   logic       a_ready, b_ready;
   logic [1:0] a_op, b_op;
   logic [2:0] a_idx, b_idx;
   logic [1:0] reg_inst;
   logic [2:0] reg_idx;
   logic       reg_in0, reg_out0;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_data, rsp_err;
   logic [15:0] stat_count;

   bitxor_arb #(.RESULT_LAT(LAT), .IDX_W(3)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_idx(a_idx), .a_val(a_val),
      .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_idx(b_idx), .b_val(b_val),
      .reg_inst(reg_inst), .reg_idx(reg_idx), .reg_in0(reg_in0), .reg_out0(reg_out0),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .stat_count(stat_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Register bank environment: result appears the cycle after the query command.
   logic bank [8];
   initial for (int i = 0; i < 8; i++) bank[i] = 1'b0;
   initial reg_out0 = 1'b0;
   always @(posedge clk) begin
      if (reg_inst == 2'b00) begin
         bank[reg_idx] <= bank[reg_idx] ^ reg_in0;
      end else if (reg_inst == 2'b10) begin
         logic p;
         p = 1'b0;
         for (int i = 0; i <= int'(reg_idx); i++) p = p ^ bank[i];
         reg_out0 <= p;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: one outstanding command, responses due at fixed offsets from the grant.
   bit   chk_en = 0;
   bit   m_mem [8];
   bit   m_pref_b = 0;
   bit   pending = 0;
   bit   e_id, e_data, e_err, e_legal, e_val;
   logic [1:0] e_op;
   logic [2:0] e_idx;
   int   g_cyc, due, hs_cyc, rv_start;
   bit   rv_prev = 0;
   logic [15:0] m_cnt = 0;
   int   g_side[$], g_at[$];
   int   r_id[$], r_data[$], r_err[$], r_lat[$];
   initial for (int i = 0; i < 8; i++) m_mem[i] = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         bit ea, eb, ev, pfx;
         ea = 0; eb = 0;
         if (!pending && !reset) begin
            if (a_valid && b_valid) begin ea = !m_pref_b; eb = m_pref_b; end
            else begin ea = a_valid; eb = b_valid; end
         end
         ev = pending && (cyc >= due);
         chk("a_ready", a_ready, ea);
         chk("b_ready", b_ready, eb);
         chk("rsp_valid", rsp_valid, ev);
         if (rsp_valid && !rv_prev) rv_start = cyc;
         rv_prev = rsp_valid;
         if (ev) begin
            chk("rsp_id", rsp_id, e_id);
            chk("rsp_data", rsp_data, e_data);
            chk("rsp_err", rsp_err, e_err);
         end
         if (pending && e_legal && cyc == g_cyc + 1) begin
            chk("reg_inst_issue", reg_inst, e_op);
            chk("reg_idx", reg_idx, e_idx);
            if (e_op == 2'b00) chk("reg_in0", reg_in0, e_val);
         end else begin
            chk("reg_inst_idle", reg_inst, 2'b11);
         end
`ifdef BITXOR_ARB_STATS_EN
         chk("stat_count", stat_count, m_cnt);
`else
         chk("stat_count", stat_count, 16'd0);
`endif
         if (reset) begin
            pending = 0; m_pref_b = 0; m_cnt = 0;
         end else if (ev && rsp_ready) begin
            pending = 0; hs_cyc = cyc;
            r_id.push_back(e_id); r_data.push_back(e_data);
            r_err.push_back(e_err); r_lat.push_back(rv_start - g_cyc);
         end else if (ea || eb) begin
            e_id    = eb;
            e_op    = eb ? b_op  : a_op;
            e_idx   = eb ? b_idx : a_idx;
            e_val   = eb ? b_val : a_val;
            e_legal = (e_op == 2'b00) || (e_op == 2'b10);
            e_err   = !e_legal;
            pfx = 0;
            for (int i = 0; i <= int'(e_idx); i++) pfx = pfx ^ m_mem[i];
            e_data  = (e_op == 2'b10) ? pfx : 1'b0;
            if (e_op == 2'b00) m_mem[e_idx] = m_mem[e_idx] ^ e_val;
            pending = 1; g_cyc = cyc;
            due = cyc + (e_legal ? LAT + 2 : 1);
            m_pref_b = !eb;
            m_cnt = m_cnt + 16'd1;
            g_side.push_back(int'(eb)); g_at.push_back(cyc);
         end
      end
   end

   task automatic send(input bit side, input logic [1:0] op, input logic [2:0] idx, input logic val);
      int t;
      if (!side) begin a_valid = 1; a_op = op; a_idx = idx; a_val = val; end
      else       begin b_valid = 1; b_op = op; b_idx = idx; b_val = val; end
      t = 0;
      do begin @(negedge clk); t++; end while (!(side ? b_ready : a_ready) && t < 100);
      if (t >= 100) chk("send_timeout", 1, 0);
      @(posedge clk); #1;
      if (!side) a_valid = 0; else b_valid = 0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin @(negedge clk); t++; end while ((pending || rsp_valid) && t < 100);
      if (t >= 100) chk("idle_timeout", 1, 0);
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 reset = 1;
      @(posedge clk); #1 reset = 0;
   endtask

   initial begin
      int base, t;
      logic cd;
      reset = 1; rsp_ready = 1;
      a_valid = 0; a_op = 0; a_idx = 0; a_val = 0;
      b_valid = 0; b_op = 0; b_idx = 0; b_val = 0;
      repeat (2) @(posedge clk);
      #1 chk_en = 1;
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_reg_inst", reg_inst, 2'b11);
      chk("rst_reg_idx", reg_idx, 0);
      chk("rst_reg_in0", reg_in0, 0);
      chk("rst_rsp_fields", {rsp_id, rsp_data, rsp_err}, 3'b000);
      chk("rst_stat", stat_count, 0);
      @(posedge clk); #1 reset = 0;

      // update idx0 val1, then prefix query idx4
      send(0, 2'b00, 3'd0, 1'b1);
      send(0, 2'b10, 3'd4, 1'b0);
      wait_idle();
      chk("p1_rsp_count", r_id.size(), 2);
      chk("p1_first_id", r_id[0], 0);
      chk("p1_first_data", r_data[0], 0);
      chk("p1_query_data", r_data[1], 1);
      chk("p1_query_lat", r_lat[1], 3);

      // illegal opcode from B
      send(1, 2'b01, 3'd3, 1'b0);
      wait_idle();
      chk("ill_err", r_err[r_err.size()-1], 1);
      chk("ill_data", r_data[r_data.size()-1], 0);
      chk("ill_id", r_id[r_id.size()-1], 1);
      chk("ill_lat", r_lat[r_lat.size()-1], 1);

      // response backpressure with A waiting behind it
      rsp_ready = 0;
      send(0, 2'b10, 3'd2, 1'b0);
      a_valid = 1; a_op = 2'b10; a_idx = 3'd0; a_val = 0;
      t = 0;
      do begin @(negedge clk); t++; end while (!rsp_valid && t < 50);
      if (t >= 50) chk("stall_timeout", 1, 0);
      cd = rsp_data;
      chk("stall_data_val", cd, 1);
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", rsp_valid, 1);
         chk("stall_data", rsp_data, cd);
         chk("stall_readies", {a_ready, b_ready}, 2'b00);
      end
      @(posedge clk); #1 rsp_ready = 1;
      t = 0;
      do begin @(negedge clk); t++; end while (!a_ready && t < 50);
      if (t >= 50) chk("regrant_timeout", 1, 0);
      @(posedge clk); #1 a_valid = 0;
      chk("regrant_gap", g_at[g_at.size()-1] - hs_cyc, 1);
      wait_idle();

      // continuous contention after reset alternates A, B, A, B
      pulse_reset();
      base = g_side.size();
      a_valid = 1; a_op = 2'b10; a_idx = 3'd1; a_val = 0;
      b_valid = 1; b_op = 2'b10; b_idx = 3'd7; b_val = 0;
      repeat (40) @(posedge clk);
      #1 a_valid = 0; b_valid = 0;
      wait_idle();
      if (g_side.size() < base + 4) chk("rr_grant_count", g_side.size() - base, 4);
      else for (int i = 0; i < 4; i++) chk("rr_order", g_side[base+i], i % 2);

      // reset during WAIT of a query
      send(1, 2'b10, 3'd5, 1'b0);
      @(posedge clk); #1 reset = 1;
      @(posedge clk); #1 reset = 0;
      a_valid = 1; a_op = 2'b10; a_idx = 3'd3;
      b_valid = 1; b_op = 2'b10; b_idx = 3'd6;
      @(negedge clk);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_reg_inst", reg_inst, 2'b11);
      chk("abort_grant_a", {a_ready, b_ready}, 2'b10);
      @(posedge clk); #1 a_valid = 0; b_valid = 0;
      wait_idle();

      // grant counter
      pulse_reset();
      for (int i = 0; i < 6; i++) send(0, (i % 2) ? 2'b10 : 2'b00, 3'(i), 1'b1);
      wait_idle();
`ifdef BITXOR_ARB_STATS_EN
      chk("stat_six", stat_count, 6);
`else
      chk("stat_six", stat_count, 0);
`endif
      pulse_reset();
      @(negedge clk);
      chk("stat_cleared", stat_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/bitxor_arb.md
Name: bitxor_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 8-entry 1-bit xor register bank (REG1B8SZ-class unit).
- Accepts update and prefix-query commands from two clients and issues exactly one command at a time to the bank.
- Waits a fixed result latency, then returns a tagged response with backpressure.
- Sits between the tree-walk clients and the register bank.

Parameters:
- RESULT_LAT, 1, cycles from the bank command cycle to the cycle reg_out0 is sampled; legal range 1..7.
- IDX_W, 3, index width; bank depth is 2**IDX_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A command valid.
- a_ready  out  1  requester A command accepted this cycle.
- a_op  in  2  A opcode: 00 = xor-update, 10 = prefix-xor query, 01/11 = illegal.
- a_idx  in  IDX_W  A index.
- a_val  in  1  A update value; ignored for queries.
- b_valid, b_ready, b_op, b_idx, b_val: same as A, for requester B.
- reg_inst  out  2  bank opcode: 00 update, 10 query, 11 idle.
- reg_idx  out  IDX_W  bank index.
- reg_in0  out  1  bank data in.
- reg_out0  in  1  bank query result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  1  0 = A, 1 = B.
- rsp_data  out  1  query result; 0 for updates and errors.
- rsp_err  out  1  illegal opcode.
- stat_count  out  16  granted-command counter; see Optional Feature.

Behaviour:
- Reset values:
  - FSM = IDLE; a_ready = b_ready = 0.
  - reg_inst = 11; reg_idx = 0; reg_in0 = 0.
  - rsp_valid = 0; rsp_id = 0; rsp_data = 0; rsp_err = 0.
  - RR pointer = A preferred; stat_count = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is combinational from the valids and the RR pointer. Only the winner's ready is high.
  - Both valid: grant the preferred side; the pointer then prefers the other side.
  - Single valid: grant that side; the pointer prefers the non-granted side.
  - On grant: latch op, idx, val and id.
  - Legal op: go to ISSUE.
  - Illegal op: go to RESP with rsp_err = 1 and rsp_data = 0. No bank command is issued.
- ISSUE (1 cycle): drive reg_inst/reg_idx/reg_in0 from the latch, then go to WAIT. The bank sees exactly one non-idle opcode per command.
- WAIT:
  - reg_inst = 11.
  - Count RESULT_LAT cycles, counting the ISSUE cycle as cycle 0.
  - Query: sample reg_out0 into rsp_data in the RESULT_LAT-th cycle after ISSUE. RESULT_LAT = 1 means the cycle immediately after ISSUE.
  - Update: still waits RESULT_LAT cycles (completion ordering), with rsp_data = 0.
  - Then go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id/rsp_data/rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE. No grant happens in that same cycle.
- Latency:
  - Grant to rsp_valid = RESULT_LAT + 2 cycles for legal commands; 1 cycle for illegal.
  - Minimum command spacing = RESULT_LAT + 3 cycles.
- Readies are low in every state except IDLE, so no command is lost.
- Requester inputs are don't-care when not granted.
- Reset asserted mid-operation: abort immediately.
  - Any pending response is dropped; reg_inst returns to 11 on the next edge.
  - The pointer resets to A preferred.
- Idle bank outputs: reg_inst = 11; reg_idx and reg_in0 hold their last values.

Optional Feature:
- Macro BITXOR_ARB_STATS_EN.
- Defined: stat_count increments by 1 on every grant, including illegal ops. It wraps 16'hFFFF to 0 and clears on reset.
- Undefined: stat_count is tied to 0 and no counter flops are generated.

Test Plan:
- Reset, then A update idx0 val1 and A query idx4. Bank model returns the xor of entries 0..4. Expect:
  - First response: rsp_id = 0, rsp_data = 0.
  - Second response: rsp_data = 1, rsp_valid exactly 3 cycles after grant (RESULT_LAT = 1).
- A and B both valid continuously with queries:
  - Grants alternate A, B, A, B starting with A after reset.
  - reg_inst = 10 for exactly one cycle per grant.
- B op = 01 idx = 3:
  - rsp_err = 1, rsp_data = 0, rsp_id = 1, one cycle after grant.
  - reg_inst stays 11 throughout.
- Hold rsp_ready = 0 for 5 cycles during RESP:
  - rsp fields stay stable; a_ready = b_ready = 0.
  - Both stay low until the handshake, then the next grant occurs in the following IDLE cycle.
- Assert reset during WAIT of a query:
  - Next cycle: rsp_valid = 0, reg_inst = 11, FSM IDLE.
  - A following A/B contention grants A.
- With BITXOR_ARB_STATS_EN defined: after 6 grants, stat_count = 6; after reset, 0. Without the macro: stat_count = 0 always.
